// File: rtl/multi_chan_sync_rx.sv
// rtl/multi_chan_sync_rx.sv - multi-channel enable-qualified receive synchronizer with valid/ready, ack toggle and overrun
module multi_chan_sync_rx #(
    parameter int CHANNELS    = 4,
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                         clk_b,
    input  logic                         brstn,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    input  logic [CHANNELS-1:0]          data_en,
    output logic [CHANNELS*DATA_W-1:0]   dataout,
    output logic [CHANNELS-1:0]          data_valid,
    input  logic [CHANNELS-1:0]          data_ready,
    output logic [CHANNELS-1:0]          ack_tgl,
    output logic [CHANNELS-1:0]          overrun,
    input  logic                         ovr_clr
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("multi_chan_sync_rx: SYNC_STAGES must be at least 2");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   en_d_q;
        logic                   en_s;
        logic                   ev;
        logic                   xfer;
        logic [DATA_W-1:0]      data_q;
        logic                   valid_q;
        logic                   ack_q;
        logic                   ovr_q;

        assign en_s = sync_q[SYNC_STAGES-1];

        if (MODE == 1) begin : g_toggle
            assign ev = en_s ^ en_d_q;
        end else begin : g_level
            assign ev = en_s & ~en_d_q;
        end

        assign xfer = valid_q & data_ready[c];

        always_ff @(posedge clk_b) begin
            if (!brstn) begin
                sync_q  <= '0;
                en_d_q  <= 1'b0;
                data_q  <= '0;
                valid_q <= 1'b0;
                ack_q   <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], data_en[c]};
                en_d_q <= en_s;

                // A full buffer being drained this cycle can take the new event directly.
                if (ev && (!valid_q || data_ready[c])) begin
                    data_q  <= data_in[c*DATA_W +: DATA_W];
                    valid_q <= 1'b1;
                end else if (xfer) begin
                    valid_q <= 1'b0;
                end

                if (xfer) begin
                    ack_q <= ~ack_q;
                end

                // Set beats clear so an overrun coincident with ovr_clr is never lost.
                if (ev && valid_q && !data_ready[c]) begin
                    ovr_q <= 1'b1;
                end else if (ovr_clr) begin
                    ovr_q <= 1'b0;
                end
            end
        end

        assign dataout[c*DATA_W +: DATA_W] = data_q;
        assign data_valid[c]               = valid_q;
        assign ack_tgl[c]                  = ack_q;
        assign overrun[c]                  = ovr_q;
    end

endmodule

// File: tb/tb_multi_chan_sync_rx.sv
// tb/tb_multi_chan_sync_rx.sv - self-checking bench: three configurations against a history-based reference model
module tb_multi_chan_sync_rx;

    logic clk_b = 1'b0;
    logic brstn;
    logic ovr_clr;

    always #5 clk_b = ~clk_b;

    // configuration 0: level mode, S=2; configuration 1: toggle mode, S=2; configuration 2: level, S=3, 8x8
    logic [15:0] din0, din1;
    logic [63:0] din2;
    logic [3:0]  en0, en1, rdy0, rdy1;
    logic [7:0]  en2, rdy2;
    logic [15:0] dout0, dout1;
    logic [63:0] dout2;
    logic [3:0]  v0, v1, a0, a1, o0, o1;
    logic [7:0]  v2, a2, o2;

    multi_chan_sync_rx #(.CHANNELS(4), .DATA_W(4), .SYNC_STAGES(2), .MODE(0)) u_lvl (
        .clk_b(clk_b), .brstn(brstn), .data_in(din0), .data_en(en0), .dataout(dout0),
        .data_valid(v0), .data_ready(rdy0), .ack_tgl(a0), .overrun(o0), .ovr_clr(ovr_clr));

    multi_chan_sync_rx #(.CHANNELS(4), .DATA_W(4), .SYNC_STAGES(2), .MODE(1)) u_tgl (
        .clk_b(clk_b), .brstn(brstn), .data_in(din1), .data_en(en1), .dataout(dout1),
        .data_valid(v1), .data_ready(rdy1), .ack_tgl(a1), .overrun(o1), .ovr_clr(ovr_clr));

    multi_chan_sync_rx #(.CHANNELS(8), .DATA_W(8), .SYNC_STAGES(3), .MODE(0)) u_wide (
        .clk_b(clk_b), .brstn(brstn), .data_in(din2), .data_en(en2), .dataout(dout2),
        .data_valid(v2), .data_ready(rdy2), .ack_tgl(a2), .overrun(o2), .ovr_clr(ovr_clr));

    logic [63:0] din_x  [3];
    logic [63:0] dout_x [3];
    logic [7:0]  en_x   [3];
    logic [7:0]  rdy_x  [3];
    logic [7:0]  vld_x  [3];
    logic [7:0]  ack_x  [3];
    logic [7:0]  ovr_x  [3];

    assign din_x[0]  = {48'b0, din0};
    assign din_x[1]  = {48'b0, din1};
    assign din_x[2]  = din2;
    assign dout_x[0] = {48'b0, dout0};
    assign dout_x[1] = {48'b0, dout1};
    assign dout_x[2] = dout2;
    assign en_x[0]   = {4'b0, en0};
    assign en_x[1]   = {4'b0, en1};
    assign en_x[2]   = en2;
    assign rdy_x[0]  = {4'b0, rdy0};
    assign rdy_x[1]  = {4'b0, rdy1};
    assign rdy_x[2]  = rdy2;
    assign vld_x[0]  = {4'b0, v0};
    assign vld_x[1]  = {4'b0, v1};
    assign vld_x[2]  = v2;
    assign ack_x[0]  = {4'b0, a0};
    assign ack_x[1]  = {4'b0, a1};
    assign ack_x[2]  = a2;
    assign ovr_x[0]  = {4'b0, o0};
    assign ovr_x[1]  = {4'b0, o1};
    assign ovr_x[2]  = o2;

    int cfg_s  [3] = '{2, 2, 3};
    int cfg_m  [3] = '{0, 1, 0};
    int cfg_nc [3] = '{4, 4, 8};
    int cfg_dw [3] = '{4, 4, 8};

    // Model: per channel a record of the enable as seen at each past clk_b edge (bit j = j edges ago),
    // plus the receive buffer expressed as occupied/data/transfer-count/overrun.
    logic [7:0] m_hist [3][8];
    logic [7:0] m_data [3][8];
    logic       m_full [3][8];
    int         m_xfers[3][8];
    logic       m_ovr  [3][8];

    int checks   = 0;
    int failures = 0;
    logic started = 1'b0;

    always @(posedge clk_b) begin
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < cfg_nc[i]; c++) begin
                if (!brstn) begin
                    m_hist[i][c]  = '0;
                    m_data[i][c]  = '0;
                    m_full[i][c]  = 1'b0;
                    m_xfers[i][c] = 0;
                    m_ovr[i][c]   = 1'b0;
                end else begin
                    logic now_en, prev_en, ev, rdy, set_ovr;
                    logic [7:0] slice;
                    now_en  = m_hist[i][c][cfg_s[i]-1];
                    prev_en = m_hist[i][c][cfg_s[i]];
                    ev      = (cfg_m[i] == 1) ? (now_en != prev_en) : (now_en && !prev_en);
                    rdy     = rdy_x[i][c];
                    slice   = 8'(din_x[i] >> (c * cfg_dw[i])) & 8'((16'd1 << cfg_dw[i]) - 16'd1);
                    set_ovr = 1'b0;
                    if (ev) begin
                        if (!m_full[i][c]) begin
                            m_data[i][c] = slice;
                            m_full[i][c] = 1'b1;
                        end else if (rdy) begin
                            m_data[i][c]  = slice;
                            m_xfers[i][c] = m_xfers[i][c] + 1;
                        end else begin
                            set_ovr = 1'b1;
                        end
                    end else if (m_full[i][c] && rdy) begin
                        m_full[i][c]  = 1'b0;
                        m_xfers[i][c] = m_xfers[i][c] + 1;
                    end
                    if (set_ovr) m_ovr[i][c] = 1'b1;
                    else if (ovr_clr) m_ovr[i][c] = 1'b0;
                    m_hist[i][c] = {m_hist[i][c][6:0], en_x[i][c]};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_b) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [63:0] e_d;
                logic [7:0]  e_v, e_a, e_o;
                e_d = '0; e_v = '0; e_a = '0; e_o = '0;
                for (int c = 0; c < cfg_nc[i]; c++) begin
                    e_d    = e_d | (64'(m_data[i][c]) << (c * cfg_dw[i]));
                    e_v[c] = m_full[i][c];
                    e_a[c] = m_xfers[i][c][0];
                    e_o[c] = m_ovr[i][c];
                end
                chk($sformatf("model_dataout_cfg%0d", i), dout_x[i], e_d);
                chk($sformatf("model_valid_cfg%0d", i), 64'(vld_x[i]), 64'(e_v));
                chk($sformatf("model_ack_cfg%0d", i), 64'(ack_x[i]), 64'(e_a));
                chk($sformatf("model_ovr_cfg%0d", i), 64'(ovr_x[i]), 64'(e_o));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_b);
    endtask

    initial begin
        brstn = 1'b0; ovr_clr = 1'b0;
        din0 = '0; din1 = '0; din2 = '0;
        en0 = '0; en1 = '0; en2 = '0;
        rdy0 = '0; rdy1 = '0; rdy2 = '0;
        tick(2);
        started = 1'b1;
        chk("reset_valid", {56'b0, v2} | {60'b0, v0} | {60'b0, v1}, 64'd0);
        chk("reset_dataout", dout2 | {48'b0, dout0}, 64'd0);
        brstn = 1'b1;
        tick(1);

        // basic capture on cfg0 ch0, plus channel 7 slicing on the 8x8, S=3 instance
        din0[3:0] = 4'hA; en0[0] = 1'b1;
        din2[63:56] = 8'h5A; en2[7] = 1'b1;
        tick(2);
        chk("cap_not_yet", 64'(v0[0]), 64'd0);
        tick(1);
        chk("cap_valid", 64'(v0[0]), 64'd1);
        chk("cap_data", 64'(dout0[3:0]), 64'hA);
        chk("wide_not_yet", 64'(v2[7]), 64'd0);
        rdy0[0] = 1'b1;
        tick(1);
        rdy0[0] = 1'b0;
        chk("consume_valid", 64'(v0[0]), 64'd0);
        chk("consume_ack", 64'(a0[0]), 64'd1);
        chk("retain_data", 64'(dout0[3:0]), 64'hA);
        chk("wide_valid", 64'(v2), 64'h80);
        chk("wide_data", dout2, 64'h5A00_0000_0000_0000);

        // toggle mode on cfg1 ch1; falling enable on cfg0 ch0 must be ignored
        din1[7:4] = 4'h3; en1[1] = 1'b1; en0[0] = 1'b0;
        tick(3);
        chk("tgl_first", {62'b0, v1[1], 1'b0} | 64'(dout1[7:4]), 64'h3 | 64'h2);
        rdy1[1] = 1'b1; tick(1); rdy1[1] = 1'b0;
        chk("tgl_ack1", 64'(a1[1]), 64'd1);
        din1[7:4] = 4'hC; en1[1] = 1'b0;
        tick(3);
        chk("tgl_second", 64'(dout1[7:4]), 64'hC);
        chk("fall_ignored", 64'(v0[0]), 64'd0);
        rdy1[1] = 1'b1; tick(1); rdy1[1] = 1'b0;
        chk("tgl_ack2", 64'(a1[1]), 64'd0);
        chk("tgl_empty", 64'(v1[1]), 64'd0);

        // overrun on cfg0 ch2
        din0[11:8] = 4'h5; en0[2] = 1'b1; tick(3);
        en0[2] = 1'b0; tick(3);
        din0[11:8] = 4'h6; en0[2] = 1'b1; tick(3);
        chk("ovr_keep_data", 64'(dout0[11:8]), 64'h5);
        chk("ovr_set", 64'(o0[2]), 64'd1);
        en0[2] = 1'b0; tick(3);
        en0[2] = 1'b1; tick(2);
        ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
        chk("ovr_set_wins", 64'(o0[2]), 64'd1);
        ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
        chk("ovr_cleared", 64'(o0[2]), 64'd0);

        // simultaneous consume + event on cfg0 ch3
        din0[15:12] = 4'h1; en0[3] = 1'b1; tick(3);
        chk("sim_pre", 64'(dout0[15:12]), 64'h1);
        en0[3] = 1'b0; tick(3);
        din0[15:12] = 4'h7; en0[3] = 1'b1; tick(2);
        rdy0[3] = 1'b1; tick(1); rdy0[3] = 1'b0;
        chk("sim_data", 64'(dout0[15:12]), 64'h7);
        chk("sim_valid", 64'(v0[3]), 64'd1);
        chk("sim_ack", 64'(a0[3]), 64'd1);
        chk("sim_no_ovr", 64'(o0[3]), 64'd0);
        rdy0[3] = 1'b1; tick(1); rdy0[3] = 1'b0;
        chk("sim_drain_ack", 64'(a0[3]), 64'd0);

        // reset mid-sync, then release with all enables high
        en0 = 4'hF; tick(1);
        brstn = 1'b0; tick(1);
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_data", 64'(dout0), 64'd0);
        chk("rst_ack_ovr", 64'({a0, o0}), 64'd0);
        brstn = 1'b1; din0 = 16'h4321;
        tick(2);
        chk("rel_not_yet", 64'(v0), 64'd0);
        tick(1);
        chk("rel_valid", 64'(v0), 64'hF);
        chk("rel_data", 64'(dout0), 64'h4321);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
